// File: rtl/cmd_cfg_gen_if.sv
// Command/response and sample-RAM signals between cmd_cfg_gen and its neighbours.
// Handshake: cmd is valid while cmd_rdy is high; a one-cycle clr_cmd_rdy consumes it. resp is valid on the send_resp pulse; resp_sent completes it.
interface cmd_cfg_gen_if #(
    parameter int NUM_CH = 5,
    parameter int LOG2   = 9
);
    logic [15:0]         cmd;
    logic                cmd_rdy;
    logic                clr_cmd_rdy;
    logic [7:0]          resp;
    logic                send_resp;
    logic                resp_sent;
    logic [LOG2-1:0]     waddr;
    logic [LOG2-1:0]     raddr;
    logic [NUM_CH*8-1:0] rdata;
    logic                rd_done;

    modport master (
        output cmd, cmd_rdy, resp_sent, waddr, rdata,
        input  clr_cmd_rdy, resp, send_resp, raddr, rd_done
    );

    modport slave (
        input  cmd, cmd_rdy, resp_sent, waddr, rdata,
        output clr_cmd_rdy, resp, send_resp, raddr, rd_done
    );
endinterface

// File: rtl/cmd_cfg_gen.sv
// Command decoder and configuration register file for the logic-analyzer capture path.
// Serves register read/write commands and streams per-channel sample dumps, oldest first.
module cmd_cfg_gen #(
    parameter int NUM_CH = 5,
    parameter int LOG2   = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    cmd_cfg_gen_if.slave        bus,
    input  logic                set_capture_done,
    output logic [5:0]          TrigCfg,
    output logic [NUM_CH*5-1:0] CHTrigCfg,
    output logic [3:0]          decimator,
    output logic [7:0]          VIH,
    output logic [7:0]          VIL,
    output logic [7:0]          matchH,
    output logic [7:0]          matchL,
    output logic [7:0]          maskH,
    output logic [7:0]          maskL,
    output logic [15:0]         baud_cnt,
    output logic [LOG2-1:0]     trig_pos,
    output logic [2:0]          fsm_state
);
    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'hEE;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_RESP = 3'd1,
        DUMP_RD   = 3'd2,
        DUMP_SEND = 3'd3,
        DUMP_WAIT = 3'd4
    } state_t;

    state_t          state, state_n;
    logic [7:0]      resp_q, resp_n;
    logic            send_q, send_n;
    logic            clr_q, clr_n;
    logic            done_q, done_n;
    logic [LOG2-1:0] raddr_q, raddr_n;
    logic [LOG2-1:0] cnt_q, cnt_n;
    logic [2:0]      ch_q, ch_n;

    logic [4:0]  ch_cfg [NUM_CH];
    logic [1:0]  opcode;
    logic [5:0]  addr;
    logic [7:0]  data;
    logic        addr_ok;
    logic [7:0]  rd_val;
    logic        reg_wr;
    logic        dump_ok;
    logic [7:0]  ch_byte;
    logic [15:0] tp_ext, tp_hi, tp_lo;

    assign opcode  = bus.cmd[15:14];
    assign addr    = bus.cmd[13:8];
    assign data    = bus.cmd[7:0];
    assign tp_ext  = 16'(trig_pos);
    assign tp_hi   = {data, tp_ext[7:0]};
    assign tp_lo   = {tp_ext[15:8], data};
    assign reg_wr  = (state == IDLE) && bus.cmd_rdy && (opcode == 2'b01) && addr_ok;
    assign dump_ok = TrigCfg[5] && ({1'b0, bus.cmd[2:0]} < 4'(NUM_CH));

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_out
        assign CHTrigCfg[g*5 +: 5] = ch_cfg[g];
    end

    // Channel registers sit at 0x01..NUM_CH; anything not listed is unmapped.
    always_comb begin
        addr_ok = 1'b1;
        rd_val  = 8'h00;
        case (addr)
            6'h00: rd_val = {2'b00, TrigCfg};
            6'h0B: rd_val = {4'h0, decimator};
            6'h0C: rd_val = VIH;
            6'h0D: rd_val = VIL;
            6'h0E: rd_val = matchH;
            6'h0F: rd_val = matchL;
            6'h10: rd_val = maskH;
            6'h11: rd_val = maskL;
            6'h12: rd_val = baud_cnt[15:8];
            6'h13: rd_val = baud_cnt[7:0];
            6'h14: rd_val = tp_ext[15:8];
            6'h15: rd_val = tp_ext[7:0];
            default: begin
                addr_ok = 1'b0;
                for (int n = 0; n < NUM_CH; n++) begin
                    if (addr == 6'(n + 1)) begin
                        addr_ok = 1'b1;
                        rd_val  = {3'b000, ch_cfg[n]};
                    end
                end
            end
        endcase
    end

    always_comb begin
        ch_byte = 8'h00;
        for (int n = 0; n < NUM_CH; n++) begin
            if (ch_q == 3'(n)) ch_byte = bus.rdata[n*8 +: 8];
        end
    end

    // A TrigCfg write is applied after the capture-done set so the write wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            TrigCfg   <= 6'h03;
            for (int n = 0; n < NUM_CH; n++) ch_cfg[n] <= 5'h01;
            decimator <= 4'h0;
            VIH       <= 8'hAA;
            VIL       <= 8'h55;
            matchH    <= 8'h00;
            matchL    <= 8'h00;
            maskH     <= 8'h00;
            maskL     <= 8'h00;
            baud_cnt  <= 16'h06C8;
            trig_pos  <= LOG2'(1);
        end else begin
            if (set_capture_done) TrigCfg[5] <= 1'b1;
            if (reg_wr) begin
                case (addr)
                    6'h00: TrigCfg        <= data[5:0];
                    6'h0B: decimator      <= data[3:0];
                    6'h0C: VIH            <= data;
                    6'h0D: VIL            <= data;
                    6'h0E: matchH         <= data;
                    6'h0F: matchL         <= data;
                    6'h10: maskH          <= data;
                    6'h11: maskL          <= data;
                    6'h12: baud_cnt[15:8] <= data;
                    6'h13: baud_cnt[7:0]  <= data;
                    6'h14: trig_pos       <= tp_hi[LOG2-1:0];
                    6'h15: trig_pos       <= tp_lo[LOG2-1:0];
                    default: ;
                endcase
                for (int n = 0; n < NUM_CH; n++) begin
                    if (addr == 6'(n + 1)) ch_cfg[n] <= data[4:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            resp_q  <= 8'h00;
            send_q  <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            raddr_q <= '0;
            cnt_q   <= '0;
            ch_q    <= 3'd0;
        end else begin
            state   <= state_n;
            resp_q  <= resp_n;
            send_q  <= send_n;
            clr_q   <= clr_n;
            done_q  <= done_n;
            raddr_q <= raddr_n;
            cnt_q   <= cnt_n;
            ch_q    <= ch_n;
        end
    end

    always_comb begin
        state_n = state;
        resp_n  = resp_q;
        send_n  = 1'b0;
        clr_n   = 1'b0;
        done_n  = 1'b0;
        raddr_n = raddr_q;
        cnt_n   = cnt_q;
        ch_n    = ch_q;
        case (state)
            IDLE: begin
                if (bus.cmd_rdy) begin
                    clr_n   = 1'b1;
                    send_n  = 1'b1;
                    resp_n  = NAK;
                    state_n = WAIT_RESP;
                    case (opcode)
                        2'b00: if (addr_ok) resp_n = rd_val;
                        2'b01: if (addr_ok) resp_n = ACK;
                        2'b10: begin
                            // A valid dump sends no ACK; the first sample byte is the reply.
                            if (dump_ok) begin
                                send_n  = 1'b0;
                                raddr_n = bus.waddr;
                                cnt_n   = '0;
                                ch_n    = bus.cmd[2:0];
                                state_n = DUMP_RD;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            WAIT_RESP: if (bus.resp_sent) state_n = IDLE;
            DUMP_RD:   state_n = DUMP_SEND;
            DUMP_SEND: begin
                resp_n  = ch_byte;
                send_n  = 1'b1;
                state_n = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                if (bus.resp_sent) begin
                    if (cnt_q == {LOG2{1'b1}}) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        raddr_n = raddr_q + 1'b1;
                        cnt_n   = cnt_q + 1'b1;
                        state_n = DUMP_RD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.resp        = resp_q;
    assign bus.send_resp   = send_q;
    assign bus.clr_cmd_rdy = clr_q;
    assign bus.rd_done     = done_q;
    assign bus.raddr       = raddr_q;
    assign fsm_state       = state;
endmodule

// File: doc/cmd_cfg_gen.md
Name: cmd_cfg_gen

Overview:
Parametrised command decoder and configuration register file for the logic-analyzer capture path. It sits between the UART command receiver/response transmitter and the capture/trigger logic. It executes read-register, write-register and channel-dump commands over NUM_CH channels. Dumps stream DEPTH=2^LOG2 samples from the sample RAM, oldest first, with RAM address wrap-around and guard checks.

Parameters:
NUM_CH, 5, number of capture channels (1..8); sets the channel-config register count and the rdata width
LOG2, 9, sample RAM address width; DEPTH = 2^LOG2 samples per channel

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd  in  16  command word: [15:14] opcode, [13:8] register address, [7:0] data; [2:0] is the channel index for a dump
cmd_rdy  in  1  command word valid
clr_cmd_rdy  out  1  one-cycle pulse acknowledging consumption of cmd
resp  out  8  response byte, held between send_resp pulses
send_resp  out  1  one-cycle pulse requesting UART transmit of resp
resp_sent  in  1  UART finished transmitting the byte
set_capture_done  in  1  capture complete; sets TrigCfg[5]
waddr  in  LOG2  RAM pointer to the oldest captured sample
raddr  out  LOG2  sample RAM read address
rdata  in  NUM_CH*8  RAM read data, channel n at [8n+7:8n], 1-cycle read latency
rd_done  out  1  one-cycle pulse after the last dump byte is sent
TrigCfg  out  6  trigger config; bit5 = capture_done
CHTrigCfg  out  NUM_CH*5  per-channel trigger config, channel n at [5n+4:5n]
decimator  out  4  sample decimation
VIH, VIL  out  8 each  threshold DAC values
matchH, matchL, maskH, maskL  out  8 each  protocol match/mask
baud_cnt  out  16  {baud_cntH, baud_cntL}
trig_pos  out  LOG2  {trig_posH, trig_posL}[LOG2-1:0]

Behaviour:
- Opcodes: 00 = read register, 01 = write register, 10 = dump, 11 = reserved (NAK).
- Register map: 0x00 TrigCfg; 0x01..NUM_CH CHnTrigCfg (n = addr-1); 0x0B decimator; 0x0C VIH; 0x0D VIL; 0x0E matchH; 0x0F matchL; 0x10 maskH; 0x11 maskL; 0x12 baud_cntH; 0x13 baud_cntL; 0x14 trig_posH; 0x15 trig_posL. Any other address is unmapped.
- Reset values:
  - TrigCfg 0x03; every CHnTrigCfg 0x01; decimator 0x0; VIH 0xAA; VIL 0x55; match/mask 0x00; baud_cnt 0x06C8; trig_posH 0x00, trig_posL 0x01.
  - resp 0x00; send_resp, clr_cmd_rdy, rd_done 0; raddr 0; state IDLE.
- Register widths: writes truncate data to the register width; reads zero-extend to 8 bits.
- States: IDLE, WAIT_RESP, DUMP_RD, DUMP_SEND, DUMP_WAIT.
- IDLE with cmd_rdy sampled high at edge T:
  - clr_cmd_rdy pulses in the T+1 cycle.
  - Read: resp = register value (or NAK 0xEE if unmapped); send_resp pulses at T+1; go to WAIT_RESP.
  - Write: register updates at edge T (visible at T+1); resp = ACK 0xA5 (NAK 0xEE if unmapped, no register change); send_resp at T+1; go to WAIT_RESP.
  - Dump: NAK 0xEE → WAIT_RESP if cmd[2:0] >= NUM_CH or TrigCfg[5]==0. Otherwise raddr <= waddr, byte count <= 0, go to DUMP_RD; no ACK byte is sent.
  - Reserved opcode: NAK 0xEE → WAIT_RESP.
- WAIT_RESP: hold until resp_sent, then IDLE.
- DUMP_RD: hold raddr for one cycle (RAM latency), then DUMP_SEND.
- DUMP_SEND: resp <= rdata byte of the selected channel; send_resp pulses; go to DUMP_WAIT.
- DUMP_WAIT on resp_sent:
  - If count == DEPTH-1: rd_done pulses the next cycle, then IDLE.
  - Else: raddr <= raddr+1 (mod DEPTH, wraps to 0), count++, go to DUMP_RD.
- cmd_rdy outside IDLE is ignored and not cleared; it is serviced on return to IDLE. resp_sent outside the WAIT states is ignored.
- set_capture_done sets TrigCfg[5] in any state. A simultaneous TrigCfg write takes priority. Writing bit5 = 0 clears capture_done.
- Asserting rst_n mid-dump aborts: all registers and outputs return to reset values immediately.

Test Plan:
- Reset, then read 0x12, 0x13, 0x0C → responses 0x06, 0xC8, 0xAA. Each send_resp exactly one cycle after cmd_rdy, clr_cmd_rdy one cycle wide.
- Write 0x0B data 0xF7 → ACK 0xA5, decimator = 0x7; read back 0x0B → 0x07. Write to addr 0x3F → NAK 0xEE, no register changes.
- With LOG2=3, set_capture_done, waddr=6, dump ch2 with RAM ch2[i]=i*0x11 → 8 bytes: 0x66, 0x77, 0x00, 0x11 … 0x55; raddr sequence 6,7,0..5; one rd_done pulse after the 8th resp_sent.
- Dump before capture done, and dump of ch 5 with NUM_CH=5 → single NAK 0xEE, raddr unchanged, no rd_done.
- Same-cycle set_capture_done and TrigCfg write of 0x03 → TrigCfg = 0x03. A later set_capture_done → 0x23.
- rst_n asserted after 3 dump bytes → outputs/regs at reset values. New cmd_rdy during a dump stays pending and is acknowledged only after rd_done.
